// File: rtl/smem_blitter.sv
// smem_blitter - rectangle-fill engine for the 40x30 character screen memory.
//
// On a start request the engine writes one charcode into every cell of a
// rectangle (clipped to the screen edges), one cell per clock, sweeping
// row-major. It sits in front of smem's write port. Direct CPU writes pass
// straight through and always win over blitter writes; a CPU write cycle
// stalls the blitter without losing its position.
//
// Ports:
//   clk, reset          - clock (clk12) and synchronous active-high reset
//   start               - fill request, honoured only while idle
//   row0, col0          - top-left cell of the rectangle
//   height, width       - rectangle extents, zero allowed
//   fill_char           - charcode written into every cell
//   busy                - high while cells are being written
//   done                - one-cycle pulse when a fill completes
//   cpu_wr/addr/wdata   - CPU direct write port (pass-through, highest priority)
//   smem_wr/addr/wdata  - write port towards smem
module smem_blitter #(
  parameter int Nchars    = 64,
  parameter int Ncols     = 40,
  parameter int Nrows     = 30,
  parameter int smem_size = 1200
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(Nrows)-1:0]     row0,
  input  logic [$clog2(Ncols)-1:0]     col0,
  input  logic [$clog2(Nrows+1)-1:0]   height,
  input  logic [$clog2(Ncols+1)-1:0]   width,
  input  logic [$clog2(Nchars)-1:0]    fill_char,
  output logic                         busy,
  output logic                         done,
  input  logic                         cpu_wr,
  input  logic [$clog2(smem_size)-1:0] cpu_addr,
  input  logic [$clog2(Nchars)-1:0]    cpu_wdata,
  output logic                         smem_wr,
  output logic [$clog2(smem_size)-1:0] smem_addr,
  output logic [$clog2(Nchars)-1:0]    smem_wdata
);

  localparam int AW = $clog2(smem_size);
  localparam int CW = $clog2(Nchars);
  // One spare bit so intermediate sums (e.g. rowbase after the last row)
  // never wrap.
  localparam int XW = AW + 1;
  localparam logic [XW-1:0] NCOLS_X = XW'(Ncols);
  localparam logic [XW-1:0] NROWS_X = XW'(Nrows);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   col_q, col_d;
  logic [XW-1:0]   col_first_q, col_first_d;
  logic [XW-1:0]   col_last_q, col_last_d;
  logic [XW-1:0]   rows_left_q, rows_left_d;
  logic [XW-1:0]   rowbase_q, rowbase_d;
  logic [CW-1:0]   char_q, char_d;

  logic [XW-1:0]   row0_x, col0_x, width_x, height_x;
  logic [XW-1:0]   col_room, row_room;
  logic [XW-1:0]   ew, eh;
  logic [XW-1:0]   rowbase_init;
  logic            zero_area;
  logic            write_ok;
  logic            last_col;
  logic            last_row;

  // Clip the requested rectangle against the screen. A start corner off
  // screen yields a zero extent, which sends the FSM straight to DONE.
  always_comb begin
    row0_x   = XW'(row0);
    col0_x   = XW'(col0);
    width_x  = XW'(width);
    height_x = XW'(height);
    col_room = NCOLS_X - col0_x;
    row_room = NROWS_X - row0_x;
    if (col0_x >= NCOLS_X) begin
      ew = '0;
    end else if (width_x < col_room) begin
      ew = width_x;
    end else begin
      ew = col_room;
    end
    if (row0_x >= NROWS_X) begin
      eh = '0;
    end else if (height_x < row_room) begin
      eh = height_x;
    end else begin
      eh = row_room;
    end
    zero_area = (ew == '0) || (eh == '0);
  end

  // row0*Ncols as a constant shift-add: one shifted copy of row0 per set bit
  // of Ncols (row0*32 + row0*8 for a 40-column screen).
  always_comb begin
    rowbase_init = '0;
    for (int i = 0; i < XW; i++) begin
      if (NCOLS_X[i]) begin
        rowbase_init = rowbase_init + (row0_x << i);
      end
    end
  end

  assign write_ok = (state_q == FILL) && !cpu_wr;
  assign last_col = (col_q == col_last_q);
  assign last_row = (rows_left_q == XW'(1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      col_first_q <= '0;
      col_last_q  <= '0;
      rows_left_q <= '0;
      rowbase_q   <= '0;
      char_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      col_first_q <= col_first_d;
      col_last_q  <= col_last_d;
      rows_left_q <= rows_left_d;
      rowbase_q   <= rowbase_d;
      char_q      <= char_d;
    end
  end

  // Next-state logic. FILL only advances on cycles where the cell was
  // actually written (no CPU write stealing the port).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = zero_area ? DONE : FILL;
        end
      end
      FILL: begin
        if (write_ok && last_col && last_row) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sweep counters. At the end of a row the column snaps back to col0 and
  // rowbase steps by one screen row, so the next row starts on the very
  // next accepted cycle.
  always_comb begin
    col_d       = col_q;
    col_first_d = col_first_q;
    col_last_d  = col_last_q;
    rows_left_d = rows_left_q;
    rowbase_d   = rowbase_q;
    char_d      = char_q;
    if ((state_q == IDLE) && start) begin
      col_d       = col0_x;
      col_first_d = col0_x;
      col_last_d  = col0_x + ew - XW'(1);
      rows_left_d = eh;
      rowbase_d   = rowbase_init;
      char_d      = fill_char;
    end else if (write_ok) begin
      if (last_col) begin
        col_d       = col_first_q;
        rowbase_d   = rowbase_q + NCOLS_X;
        rows_left_d = rows_left_q - XW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
    end
  end

  // Outputs and write-port arbitration. The CPU path is purely
  // combinational; the blitter path depends only on registered state.
  always_comb begin
    busy       = (state_q == FILL);
    done       = (state_q == DONE);
    smem_wr    = cpu_wr;
    smem_addr  = cpu_addr;
    smem_wdata = cpu_wdata;
    if (write_ok) begin
      smem_wr    = 1'b1;
      smem_addr  = AW'(rowbase_q + col_q);
      smem_wdata = char_q;
    end
  end

endmodule

// File: tb/tb_smem_blitter.sv
// tb_smem_blitter - self-checking bench for smem_blitter.
//
// A queue-based reference model expands each accepted start into the list of
// cell addresses it must write and is compared against the DUT write port,
// busy and done on every cycle. Directed fills pin the model with
// hand-computed addresses and cycle numbers; randomized fills with random CPU
// traffic exercise clipping and stalls.
module tb_smem_blitter;

  localparam int NCOLS = 40;
  localparam int NROWS = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  row0;
  logic [5:0]  col0;
  logic [4:0]  height;
  logic [5:0]  width;
  logic [5:0]  fill_char;
  logic        busy;
  logic        done;
  logic        cpu_wr;
  logic [10:0] cpu_addr;
  logic [5:0]  cpu_wdata;
  logic        smem_wr;
  logic [10:0] smem_addr;
  logic [5:0]  smem_wdata;

  smem_blitter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .row0       (row0),
    .col0       (col0),
    .height     (height),
    .width      (width),
    .fill_char  (fill_char),
    .busy       (busy),
    .done       (done),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .smem_wr    (smem_wr),
    .smem_addr  (smem_addr),
    .smem_wdata (smem_wdata)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int startCyc = 0;

  // Reference model: 0 idle, 1 filling, 2 done-pulse cycle.
  int        modelMode = 0;
  int        modelCells[$];
  logic [5:0] modelChar = '0;
  bit        checkingOn = 1'b0;

  // Observation logs for the current fill, cycle numbers relative to start.
  int  blitAddrLog[$];
  int  blitDataLog[$];
  int  blitRelLog[$];
  int  cpuAddrLog[$];
  int  cpuDataLog[$];
  int  cpuRelLog[$];
  int  doneRel   = -1;
  bit  doneSeen  = 1'b0;
  int  doneCount = 0;
  int  busyCount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Expand a request into its clipped list of cell addresses, row-major.
  task automatic buildCells(input int r, input int c, input int h, input int w);
    int ew;
    int eh;
    modelCells.delete();
    ew = (c >= NCOLS) ? 0 : ((w < NCOLS - c) ? w : NCOLS - c);
    eh = (r >= NROWS) ? 0 : ((h < NROWS - r) ? h : NROWS - r);
    for (int rr = 0; rr < eh; rr++) begin
      for (int cc = 0; cc < ew; cc++) begin
        modelCells.push_back((r + rr) * NCOLS + c + cc);
      end
    end
  endtask

  // Compare DUT against the model mid-cycle, log what was seen, then step
  // the model with the inputs the next rising edge will sample.
  always @(negedge clk) begin
    logic       expWr;
    int         expAddr;
    logic [5:0] expData;
    if (checkingOn) begin
      expWr   = 1'b0;
      expAddr = 0;
      expData = '0;
      if (cpu_wr) begin
        expWr   = 1'b1;
        expAddr = cpu_addr;
        expData = cpu_wdata;
      end else if (modelMode == 1) begin
        expWr   = 1'b1;
        expAddr = modelCells[0];
        expData = modelChar;
      end
      checkOutput("busy", busy, (modelMode == 1));
      checkOutput("done", done, (modelMode == 2));
      checkOutput("smem_wr", smem_wr, expWr);
      if (expWr) begin
        checkOutput("smem_addr", smem_addr, expAddr);
        checkOutput("smem_wdata", smem_wdata, expData);
      end
      if (smem_wr === 1'b1 && cpu_wr === 1'b0) begin
        blitAddrLog.push_back(smem_addr);
        blitDataLog.push_back(smem_wdata);
        blitRelLog.push_back(cyc - startCyc);
      end
      if (cpu_wr === 1'b1) begin
        cpuAddrLog.push_back(smem_addr);
        cpuDataLog.push_back(smem_wdata);
        cpuRelLog.push_back(cyc - startCyc);
      end
      if (done === 1'b1) begin
        doneSeen = 1'b1;
        doneRel  = cyc - startCyc;
        doneCount++;
      end
      if (busy === 1'b1) busyCount++;
    end
    if (reset) begin
      modelMode = 0;
      modelCells.delete();
      checkingOn = 1'b1;
    end else if (modelMode == 0) begin
      if (start === 1'b1) begin
        buildCells(row0, col0, height, width);
        modelChar = fill_char;
        startCyc  = cyc;
        modelMode = (modelCells.size() > 0) ? 1 : 2;
      end
    end else if (modelMode == 1) begin
      if (!cpu_wr) void'(modelCells.pop_front());
      if (modelCells.size() == 0) modelMode = 2;
    end else begin
      modelMode = 0;
    end
  end

  // Issue one fill and drive cycles until done (or until the cycle after a
  // planned reset). cpuAt/restartAt/resetAt are cycle numbers after start,
  // 0 meaning unused.
  task automatic applyStimulus(input int r, input int c, input int h, input int w,
                               input int ch, input int cpuPct, input int cpuAt,
                               input int restartAt, input int resetAt, input int budget);
    bit finished;
    blitAddrLog.delete(); blitDataLog.delete(); blitRelLog.delete();
    cpuAddrLog.delete();  cpuDataLog.delete();  cpuRelLog.delete();
    doneSeen = 1'b0; doneRel = -1; doneCount = 0; busyCount = 0;
    finished = 1'b0;
    @(posedge clk); #1;
    row0 = 5'(r); col0 = 6'(c); height = 5'(h); width = 6'(w);
    fill_char = 6'(ch); start = 1'b1; cpu_wr = 1'b0;
    for (int rel = 1; rel <= budget; rel++) begin
      @(posedge clk); #1;
      if (doneSeen || (resetAt != 0 && rel == resetAt + 1)) begin
        finished = 1'b1;
        break;
      end
      start = 1'b0;
      if (rel == restartAt) begin
        start = 1'b1;
        row0 = 5'($urandom_range(29)); col0 = 6'($urandom_range(39));
        height = 5'($urandom_range(30)); width = 6'($urandom_range(40));
        fill_char = 6'($urandom);
      end
      if (rel == cpuAt) begin
        cpu_wr = 1'b1; cpu_addr = 11'd500; cpu_wdata = 6'h3F;
      end else if ($urandom_range(99) < cpuPct) begin
        cpu_wr = 1'b1; cpu_addr = 11'($urandom_range(1199)); cpu_wdata = 6'($urandom);
      end else begin
        cpu_wr = 1'b0;
      end
      reset = (rel == resetAt);
    end
    start = 1'b0; cpu_wr = 1'b0; reset = 1'b0;
    if (!finished) checkOutput("fill_timeout", 0, 1);
  endtask

  initial begin
    int bad;
    int expSmall[6];
    reset = 1'b1; start = 1'b0; row0 = '0; col0 = '0; height = '0; width = '0;
    fill_char = '0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_smem_wr", smem_wr, 0);
    cpu_wr = 1'b1; cpu_addr = 11'd7; cpu_wdata = 6'h05;
    #1;
    checkOutput("reset_passthru_wr", smem_wr, 1);
    checkOutput("reset_passthru_addr", smem_addr, 7);
    cpu_wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] full-screen fill");
    applyStimulus(0, 0, 30, 40, 'h20, 0, 0, 0, 0, 1300);
    checkOutput("full_count", blitAddrLog.size(), 1200);
    bad = 0;
    foreach (blitAddrLog[i]) begin
      if (blitAddrLog[i] != i || blitDataLog[i] != 'h20 || blitRelLog[i] != i + 1) bad++;
    end
    checkOutput("full_sequence_errors", bad, 0);
    checkOutput("full_done_cycle", doneRel, 1201);
    checkOutput("full_busy_cycles", busyCount, 1200);

    $display("[TB] small rectangle");
    expSmall = '{85, 86, 87, 125, 126, 127};
    applyStimulus(2, 5, 2, 3, 'h11, 0, 0, 0, 0, 50);
    checkOutput("small_count", blitAddrLog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < blitAddrLog.size()) checkOutput("small_addr", blitAddrLog[i], expSmall[i]);
    end
    checkOutput("small_done_cycle", doneRel, 7);

    $display("[TB] clipping");
    applyStimulus(29, 38, 5, 10, 'h01, 0, 0, 0, 0, 50);
    checkOutput("clip_count", blitAddrLog.size(), 2);
    if (blitAddrLog.size() == 2) begin
      checkOutput("clip_addr0", blitAddrLog[0], 1198);
      checkOutput("clip_addr1", blitAddrLog[1], 1199);
    end
    checkOutput("clip_done_cycle", doneRel, 3);
    applyStimulus(3, 3, 4, 0, 'h01, 0, 0, 0, 0, 50);
    checkOutput("zero_count", blitAddrLog.size(), 0);
    checkOutput("zero_done_cycle", doneRel, 1);
    checkOutput("zero_busy_cycles", busyCount, 0);

    $display("[TB] cpu priority");
    applyStimulus(2, 5, 2, 3, 'h11, 0, 2, 0, 0, 50);
    checkOutput("cpu_count", cpuAddrLog.size(), 1);
    if (cpuAddrLog.size() == 1) begin
      checkOutput("cpu_addr", cpuAddrLog[0], 500);
      checkOutput("cpu_data", cpuDataLog[0], 'h3F);
      checkOutput("cpu_cycle", cpuRelLog[0], 2);
    end
    if (blitAddrLog.size() >= 2) begin
      checkOutput("stalled_addr", blitAddrLog[1], 86);
      checkOutput("stalled_cycle", blitRelLog[1], 3);
    end
    checkOutput("cpu_done_cycle", doneRel, 8);

    $display("[TB] ignored start");
    applyStimulus(2, 5, 2, 3, 'h11, 0, 0, 3, 0, 50);
    checkOutput("ignored_count", blitAddrLog.size(), 6);
    if (blitAddrLog.size() == 6) checkOutput("ignored_last_addr", blitAddrLog[5], 127);
    checkOutput("ignored_done_cycle", doneRel, 7);

    $display("[TB] reset abort");
    applyStimulus(2, 5, 2, 3, 'h11, 0, 0, 2, 3, 50);
    #1;
    checkOutput("abort_smem_wr", smem_wr, 0);
    checkOutput("abort_busy", busy, 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("abort_writes", blitAddrLog.size(), 3);
    checkOutput("abort_done_pulses", doneCount, 0);
    applyStimulus(1, 1, 1, 1, 'h2A, 0, 0, 0, 0, 50);
    checkOutput("after_abort_done_cycle", doneRel, 2);
    if (blitAddrLog.size() == 1) checkOutput("after_abort_addr", blitAddrLog[0], 41);
    else checkOutput("after_abort_count", blitAddrLog.size(), 1);

    $display("[TB] randomized fills");
    for (int k = 0; k < 40; k++) begin
      applyStimulus($urandom_range(31), $urandom_range(63), $urandom_range(31),
                    $urandom_range(63), $urandom_range(63), 20, 0,
                    $urandom_range(4), 0, 3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
